mem_dma: RTL and testbench
==========================

# mem_dma

Single-channel block-copy engine that sits on the requester side of the single-port data memory. It drives the memory's address, write-enable and write-data pins and consumes its combinational read data. Given source, destination and length, it copies bytes one at a time, one memory operation per granted cycle. The copy runs while the datapath has yielded the port via `MemGrant`.

## Interface
Parameters:
- `W`, 8, data width; must match the data memory, fixed at 8.
- `A`, 8, address width; the memory has 2**A entries.

Ports:
- Clocking: one clock `Clk`. Reset is synchronous and active-high, on port `Reset`.
- `Clk`  in  1  clock; all state updates on posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request a transfer; sampled only in IDLE.
- `SrcAddr`  in  A  first source address.
- `DstAddr`  in  A  first destination address.
- `Len`  in  A+1  byte count, 0..2**A; values above 2**A saturate to 2**A.
- `MemGrant`  in  1  memory port granted to this engine this cycle.
- `MemDataIn`  in  W  memory read data (combinational from `MemAddress`).
- `MemAddress`  out  A  memory address.
- `MemWriteEn`  out  1  memory write enable.
- `MemDataOut`  out  W  memory write data.
- `Busy`  out  1  high in READ and WRITE.
- `Done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `Start`=1 and `Len`≠0: latch src, dst and min(`Len`, 2**A) into `remaining`, then go to READ.
  - `Start`=1 and `Len`=0: go to DONE. No memory access occurs.
- **READ**
  - Drive `MemAddress`=src and `MemWriteEn`=0.
  - If `MemGrant`: capture `MemDataIn` into the byte buffer and go to WRITE.
  - Else: hold state.
- **WRITE**
  - Drive `MemAddress`=dst, `MemDataOut`=buffer, `MemWriteEn`=`MemGrant`.
  - If `MemGrant`: increment src and dst modulo 2**A, decrement `remaining`.
  - Then go to DONE if `remaining` was 1, else back to READ.
  - Else: hold state; the buffer is kept.
- **DONE**
  - `Done`=1 for this cycle only, `Busy`=0.
  - Unconditionally go to IDLE.
- `Start` is ignored outside IDLE; there is no queuing.
- Copy is strictly ascending, byte by byte. Overlapping regions with dst>src therefore replicate source bytes; this is the defined behaviour.
- Address wrap: 255+1 → 0. A transfer of 2**A bytes touches every address exactly once per side.
- Outputs in IDLE and DONE: `MemAddress`=0, `MemWriteEn`=0, `MemDataOut`=0.
- `MemWriteEn` is never high unless the state is WRITE and `MemGrant`=1.

## Timing
- Reset values:
  - state IDLE.
  - `Busy`=0, `Done`=0, `MemWriteEn`=0, `MemAddress`=0, `MemDataOut`=0.
  - Buffer and counters cleared.
- Reset mid-transfer: at the next edge the engine returns to IDLE. No further writes and no `Done` pulse are issued; bytes already written remain.
- Start accepted at edge 0 with constant grant:
  - READ occupies cycle 1, WRITE cycle 2, and so on; the last WRITE is cycle 2N.
  - `Done` is high in cycle 2N+1; IDLE again from cycle 2N+2.
- `Len`=0: `Done` is high in cycle 1.
- Each cycle with `MemGrant`=0 in READ or WRITE adds exactly one cycle of latency.
- A `Start` sampled in the DONE cycle is ignored. The earliest new accept is the first IDLE cycle.
- `MemAddress`, `MemDataOut` and `Busy` are functions of registered state only. `MemWriteEn` additionally has a combinational path from `MemGrant`.

## Structure
- Package `mem_dma_pkg`: the state enum typedef `mem_dma_state_t` and the length-saturation constant 2**A.
- Single module: FSM, src/dst/remaining registers and byte buffer.
- No sub-module is natural at this size.

## Test plan
- Memory reset-preloaded (128..130 = 0x60, 0x48, 0x78). Start src=128, dst=16, Len=3, grant held high. Expect:
  - mem[16..18] = 0x60, 0x48, 0x78.
  - `Done` exactly 7 cycles after the Start edge.
  - `Busy` high for 6 cycles.
- Wrap: src=254, dst=64, Len=4. Expect reads of 254, 255, 0, 1 in order and writes to 64..67.
- Grant stall: Len=2 with `MemGrant` low for 3 cycles during the first WRITE. Expect:
  - No write while grant is low; buffer preserved.
  - `Done` 3 cycles later than nominal (cycle 8).
- Len=0, then Len=300: expect `Done` in cycle 1 with no `MemWriteEn`; expect 256 writes for Len=300.
- `Reset` asserted in the WRITE of byte 2 of a 5-byte copy. Expect:
  - Only byte 1 written; no `Done`.
  - All outputs 0 the next cycle.
  - A fresh Start is accepted on the following cycle.
- `Start` pulsed with new args while `Busy`: expect it ignored; the original copy completes unchanged.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma block-copy engine.
package mem_dma_pkg;

  localparam int DMA_AW = 8;
  localparam logic [DMA_AW:0] LEN_SAT = 9'd256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } mem_dma_state_t;

endpackage

// File: rtl/mem_dma.sv
// Single-channel byte copy engine: alternates READ/WRITE on the shared data
// memory port, advancing only in cycles where the port is granted.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int W = 8,
  parameter int A = DMA_AW
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A:0]   Len,
  input  logic         MemGrant,
  input  logic [W-1:0] MemDataIn,
  output logic [A-1:0] MemAddress,
  output logic         MemWriteEn,
  output logic [W-1:0] MemDataOut,
  output logic         Busy,
  output logic         Done
);

  localparam logic [A-1:0] ADDR_ONE = A'(1);
  localparam logic [A:0]   REM_ONE  = (A+1)'(1);

  mem_dma_state_t state_q, state_d;
  logic [A-1:0]   src_q, src_d;
  logic [A-1:0]   dst_q, dst_d;
  logic [A:0]     rem_q, rem_d;
  logic [W-1:0]   buf_q, buf_d;

  // State and datapath registers with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and datapath update; nothing advances without a grant.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Len == '0) begin
            state_d = ST_DONE;
          end else begin
            src_d   = SrcAddr;
            dst_d   = DstAddr;
            rem_d   = (Len > LEN_SAT) ? LEN_SAT : Len;
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (MemGrant) begin
          buf_d   = MemDataIn;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (MemGrant) begin
          src_d   = src_q + ADDR_ONE;
          dst_d   = dst_q + ADDR_ONE;
          rem_d   = rem_q - REM_ONE;
          state_d = (rem_q == REM_ONE) ? ST_DONE : ST_READ;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Port outputs decode from registered state; the write strobe also
  // follows the grant and is suppressed while reset is being applied.
  always_comb begin
    MemAddress = '0;
    MemDataOut = '0;
    MemWriteEn = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state_q)
      ST_READ: begin
        MemAddress = src_q;
        Busy       = 1'b1;
      end
      ST_WRITE: begin
        MemAddress = dst_q;
        MemDataOut = buf_q;
        MemWriteEn = MemGrant & ~Reset;
        Busy       = 1'b1;
      end
      ST_DONE: Done = 1'b1;
      default: Busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a behavioural single-port memory.
module tb_mem_dma;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [8:0] Len;
  logic       MemGrant;
  logic [7:0] MemDataIn;
  logic [7:0] MemAddress;
  logic       MemWriteEn;
  logic [7:0] MemDataOut;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  int wr_q[$];
  int rd_q[$];

  mem_dma #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .SrcAddr(SrcAddr),
    .DstAddr(DstAddr), .Len(Len), .MemGrant(MemGrant), .MemDataIn(MemDataIn),
    .MemAddress(MemAddress), .MemWriteEn(MemWriteEn), .MemDataOut(MemDataOut),
    .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign MemDataIn = mem[MemAddress];

  // Memory write port plus a log of every read and write issued.
  always @(posedge Clk) begin
    if (MemWriteEn) begin
      mem[MemAddress] <= MemDataOut;
      wr_q.push_back(int'(MemAddress));
    end
    if (Busy && MemGrant && !MemWriteEn)
      rd_q.push_back(int'(MemAddress));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Start a copy at edge 0 and walk cycles 1..N, applying optional stall,
  // reset and stray-Start events. Returns the Done cycle and Busy count.
  task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                     input int st_from, input int st_n, input int rst_at, input int poke_at,
                     output int done_c, output int busy_n);
    wr_q.delete();
    rd_q.delete();
    SrcAddr = s; DstAddr = d; Len = l; Start = 1'b1; MemGrant = 1'b1;
    tick();
    Start = 1'b0;
    done_c = 0;
    busy_n = 0;
    for (int c = 1; c <= 600 && done_c == 0; c++) begin
      MemGrant = !(c >= st_from && c < st_from + st_n);
      Reset = (c == rst_at);
      if (c == poke_at) begin
        Start = 1'b1; SrcAddr = 8'd1; DstAddr = 8'd2; Len = 9'd7;
      end else begin
        Start = 1'b0;
      end
      if (Busy) busy_n++;
      if (Done) done_c = c;
      tick();
      if (c == rst_at) break;
    end
    MemGrant = 1'b1;
    Start = 1'b0;
    if (rst_at == 0) check("done_seen", 32'(done_c != 0), 32'd1);
  endtask

  int dc, bn, bad;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[128] = 8'h60; mem[129] = 8'h48; mem[130] = 8'h78;
    Reset = 1'b1; Start = 1'b0; SrcAddr = 8'd0; DstAddr = 8'd0; Len = 9'd0; MemGrant = 1'b1;
    tick(); tick();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_we", 32'(MemWriteEn), 32'd0);
    check("rst_addr", 32'(MemAddress), 32'd0);
    check("rst_dout", 32'(MemDataOut), 32'd0);
    Reset = 1'b0;
    tick();

    // Basic 3-byte copy 128 -> 16.
    run(8'd128, 8'd16, 9'd3, 0, 0, 0, 0, dc, bn);
    check("t1_done_cyc", 32'(dc), 32'd7);
    check("t1_busy_n", 32'(bn), 32'd6);
    check("t1_nwr", 32'(wr_q.size()), 32'd3);
    check("t1_m16", 32'(mem[16]), 32'h60);
    check("t1_m17", 32'(mem[17]), 32'h48);
    check("t1_m18", 32'(mem[18]), 32'h78);
    check("t1_idle_busy", 32'(Busy), 32'd0);
    check("t1_idle_done", 32'(Done), 32'd0);

    // Source address wrap 254,255,0,1.
    run(8'd254, 8'd64, 9'd4, 0, 0, 0, 0, dc, bn);
    check("wr_done_cyc", 32'(dc), 32'd9);
    check("wr_nrd", 32'(rd_q.size()), 32'd4);
    if (rd_q.size() == 4) begin
      check("wr_rd0", 32'(rd_q[0]), 32'd254);
      check("wr_rd1", 32'(rd_q[1]), 32'd255);
      check("wr_rd2", 32'(rd_q[2]), 32'd0);
      check("wr_rd3", 32'(rd_q[3]), 32'd1);
    end
    check("wr_nwr", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() == 4) begin
      check("wr_wa0", 32'(wr_q[0]), 32'd64);
      check("wr_wa3", 32'(wr_q[3]), 32'd67);
    end
    check("wr_m64", 32'(mem[64]), 32'h5B);
    check("wr_m65", 32'(mem[65]), 32'h5A);
    check("wr_m66", 32'(mem[66]), 32'hA5);
    check("wr_m67", 32'(mem[67]), 32'hA4);

    // Grant withheld during cycles 2..4 (first WRITE).
    run(8'd128, 8'd20, 9'd2, 2, 3, 0, 0, dc, bn);
    check("st_done_cyc", 32'(dc), 32'd8);
    check("st_busy_n", 32'(bn), 32'd7);
    check("st_nwr", 32'(wr_q.size()), 32'd2);
    check("st_m20", 32'(mem[20]), 32'h60);
    check("st_m21", 32'(mem[21]), 32'h48);

    // Zero length: immediate Done, no memory traffic.
    run(8'd5, 8'd6, 9'd0, 0, 0, 0, 0, dc, bn);
    check("z_done_cyc", 32'(dc), 32'd1);
    check("z_busy_n", 32'(bn), 32'd0);
    check("z_nwr", 32'(wr_q.size()), 32'd0);

    // Oversized length saturates to 256; every address written once in order.
    run(8'd0, 8'd0, 9'd300, 0, 0, 0, 0, dc, bn);
    check("sat_done_cyc", 32'(dc), 32'd513);
    check("sat_nwr", 32'(wr_q.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < 256; i++) if (wr_q[i] != i) bad++;
    check("sat_order", 32'(bad), 32'd0);

    // Reset during the WRITE of byte 2 (cycle 4) of a 5-byte copy.
    run(8'd128, 8'd32, 9'd5, 0, 0, 4, 0, dc, bn);
    Reset = 1'b0;
    check("rs_done", 32'(dc), 32'd0);
    check("rs_nwr", 32'(wr_q.size()), 32'd1);
    check("rs_m32", 32'(mem[32]), 32'h60);
    check("rs_m33", 32'(mem[33]), 32'h84);
    check("rs_busy", 32'(Busy), 32'd0);
    check("rs_we", 32'(MemWriteEn), 32'd0);
    check("rs_addr", 32'(MemAddress), 32'd0);
    check("rs_dout", 32'(MemDataOut), 32'd0);
    check("rs_done_now", 32'(Done), 32'd0);
    SrcAddr = 8'd130; DstAddr = 8'd48; Len = 9'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("rs_restart", 32'(Busy), 32'd1);
    tick(); tick();
    check("rs_restart_done", 32'(Done), 32'd1);
    check("rs_m48", 32'(mem[48]), 32'h78);
    tick();

    // Stray Start with new arguments while busy is ignored.
    run(8'd150, 8'd80, 9'd3, 0, 0, 0, 3, dc, bn);
    check("ig_done_cyc", 32'(dc), 32'd7);
    check("ig_nwr", 32'(wr_q.size()), 32'd3);
    check("ig_m80", 32'(mem[80]), 32'h33);
    check("ig_m81", 32'(mem[81]), 32'h32);
    check("ig_m82", 32'(mem[82]), 32'h3D);
    check("ig_m2", 32'(mem[2]), 32'hA7);
    tick(); tick();
    check("ig_idle", 32'(Busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
